// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the convolution post-processing stages.
//   CONV_DATA_W  default sample width (signed two's complement)
//   CONV_MAP_W   default input map width/height
//   pix_t        signed sample type at the default width
//   pool_state_t row-phase state of the max-pool stage
package conv_pkg;

  localparam int unsigned CONV_DATA_W = 16;
  localparam int unsigned CONV_MAP_W  = 4;

  typedef logic signed [CONV_DATA_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    ROW_EVEN,
    ROW_ODD
  } pool_state_t;

endpackage

// File: rtl/pool_max2.sv
// pool_max2: combinational signed two-input maximum.
//   i_a, i_b  signed operands
//   o_max     the larger operand (either one on a tie; they are equal)
module pool_max2
  import conv_pkg::*;
#(
  parameter int unsigned W = CONV_DATA_W
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_max
);

  assign o_max = (i_a > i_b) ? i_a : i_b;

endmodule

// File: rtl/conv_maxpool.sv
// conv_maxpool: streaming 2x2 / stride-2 max pooling of a MAP_W x MAP_W row-major map.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   one input sample this cycle (gaps allowed, no back-pressure)
//   in_data    signed input sample
//   out_valid  one-cycle pulse per pooled sample, one cycle after the window completes
//   out_data   signed pooled sample, 0 whenever out_valid is low
// Optional build macro CONV_MAXPOOL_RELU_EN: clamp negative pooled results to 0.
// Only a half-row of horizontal maxima is kept in the line buffer.
module conv_maxpool
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = CONV_DATA_W,
  parameter int unsigned MAP_W  = CONV_MAP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int unsigned CntW    = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned LbDepth = MAP_W / 2;
  localparam int unsigned LbIdxW  = (LbDepth > 1) ? $clog2(LbDepth) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(MAP_W - 1);

  pool_state_t r_state, w_state_next;

  logic [CntW-1:0]          r_col_cnt, r_row_cnt;
  logic signed [DATA_W-1:0] r_hold;
  logic signed [DATA_W-1:0] r_linebuf [LbDepth];
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;

  logic                     w_col_last, w_row_last, w_odd_col, w_even_row, w_fire;
  logic [LbIdxW-1:0]        w_lb_idx;
  logic signed [DATA_W-1:0] w_lb_rd, w_hmax, w_vmax, w_result;

  assign w_col_last = (r_col_cnt == LastIdx);
  assign w_row_last = (r_row_cnt == LastIdx);
  assign w_odd_col  = r_col_cnt[0];
  // IDLE only ever sees the first beat of a frame, which sits on row 0.
  assign w_even_row = (r_state != ROW_ODD);
  assign w_lb_idx   = LbIdxW'(r_col_cnt >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  // Bottom-right element of a 2x2 window.
  assign w_fire     = in_valid && !w_even_row && w_odd_col;

  pool_max2 #(.W(DATA_W)) u_hmax (
    .i_a   (r_hold),
    .i_b   (in_data),
    .o_max (w_hmax)
  );

  pool_max2 #(.W(DATA_W)) u_vmax (
    .i_a   (w_hmax),
    .i_b   (w_lb_rd),
    .o_max (w_vmax)
  );

`ifdef CONV_MAXPOOL_RELU_EN
  assign w_result = w_vmax[DATA_W-1] ? '0 : w_vmax;
`else
  assign w_result = w_vmax;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) w_state_next = w_col_last ? ROW_ODD : ROW_EVEN;
      end
      ROW_EVEN: begin
        if (in_valid && w_col_last) w_state_next = ROW_ODD;
      end
      ROW_ODD: begin
        if (in_valid && w_col_last) w_state_next = w_row_last ? IDLE : ROW_EVEN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (in_valid) begin
        if (w_col_last) begin
          r_col_cnt <= '0;
          r_row_cnt <= w_row_last ? '0 : r_row_cnt + CntW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      for (int unsigned i = 0; i < LbDepth; i++) r_linebuf[i] <= '0;
    end else if (in_valid) begin
      if (!w_odd_col) r_hold <= in_data;
      else if (w_even_row) r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_fire;
      r_out_data  <= w_fire ? w_result : '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv_maxpool.sv
module tb_conv_maxpool;
  import conv_pkg::*;

  localparam int MW = 4;
  localparam int NB = MW * MW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  pix_t in_data = '0;
  logic out_valid;
  pix_t out_data;

  conv_maxpool #(.DATA_W(16), .MAP_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Keeps the frame seen so far in a flat array indexed by beat position and,
  // whenever a beat lands on an odd row and odd column, takes the max of the
  // four elements of that window as the output required on the next cycle.
  int   frame [NB];
  int   pos = 0;
  logic exp_v = 1'b0;
  int   exp_d = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int relu(input int v);
`ifdef CONV_MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= 0;
      exp_v <= 1'b0;
      exp_d <= 0;
    end else if (in_valid) begin
      int v, r, c, m;
      v = int'(in_data);
      r = pos / MW;
      c = pos % MW;
      frame[pos] <= v;
      pos <= (pos + 1) % NB;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = max2(max2(frame[pos-MW-1], frame[pos-MW]), max2(frame[pos-1], v));
        exp_v <= 1'b1;
        exp_d <= relu(m);
      end else begin
        exp_v <= 1'b0;
        exp_d <= 0;
      end
    end else begin
      exp_v <= 1'b0;
      exp_d <= 0;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  int cap_q[$];
  int cap_cyc[$];
  int beat_cyc[$];

  always @(negedge clk) begin
    logic signed [15:0] want;
    want = exp_v ? 16'(exp_d) : 16'sd0;
    tests++;
    if (out_valid !== exp_v || out_data !== want) begin
      errors++;
      $display("FAIL cycle_check cyc=%0d: out_valid=%0b out_data=%0d, required valid=%0b data=%0d",
               cyc, out_valid, out_data, exp_v, want);
    end
    if (out_valid === 1'b1) begin
      cap_q.push_back(int'(out_data));
      cap_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic beat(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(v);
    beat_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'h5A5A;
    end
  endtask

  task automatic send_frame(input int f[NB], input int maxgap);
    for (int i = 0; i < NB; i++) begin
      if (maxgap > 0) idle(int'($urandom_range(1, maxgap)));
      beat(f[i]);
    end
  endtask

  task automatic clear_caps();
    cap_q.delete();
    cap_cyc.delete();
    beat_cyc.delete();
  endtask

  // Checks four captured outputs starting at cap_off against literals, and
  // that each arrived one cycle after beats 5, 7, 13, 15 of the frame at beat_base.
  task automatic check_caps(input string name, input int e[4], input int cap_off,
                            input int beat_base);
    int done[4];
    done = '{5, 7, 13, 15};
    for (int i = 0; i < 4; i++) begin
      if (cap_off + i >= cap_q.size() || beat_base + done[i] >= beat_cyc.size()) begin
        check({name, "_missing"}, cap_q.size(), cap_off + 4);
      end else begin
        check({name, "_val"}, cap_q[cap_off+i], e[i]);
        check({name, "_time"}, cap_cyc[cap_off+i], beat_cyc[beat_base+done[i]] + 1);
      end
    end
  endtask

  int fa[NB], fb[NB], fc[NB], fx[NB], fz[NB];
  int ea[4], eb[4], ec[4], ex[4], ez[4];

  initial begin
    fa = '{1, 2, 3, 4, 5, 6, 7, 8, -1, -2, -3, -4, -5, -6, -7, -8};
    for (int i = 0; i < NB; i++) begin
      fb[i] = fa[i] + 10;
      fc[i] = 20 + i;
      fz[i] = 0;
    end
    fx = '{-32768, 32767, -32768, -32768,
           -32768, -32768, -32768, -32768,
           32767, -32768, -32768, -32768,
           -32768, -32768, -32768, 32767};
`ifdef CONV_MAXPOOL_RELU_EN
    ea = '{6, 8, 0, 0};
    ex = '{32767, 0, 32767, 32767};
`else
    ea = '{6, 8, -1, -3};
    ex = '{32767, -32768, 32767, 32767};
`endif
    eb = '{16, 18, 9, 7};
    ec = '{25, 27, 33, 35};
    ez = '{0, 0, 0, 0};

    // Reset state
    in_data = 16'h5A5A;
    repeat (3) begin
      @(negedge clk);
      check("reset_valid", int'(out_valid), 0);
      check("reset_data", int'(out_data), 0);
    end
    #2 rst_n = 1'b1;
    idle(2);

    // Contiguous frame
    clear_caps();
    send_frame(fa, 0);
    idle(3);
    check("frameA_count", cap_q.size(), 4);
    check_caps("frameA", ea, 0, 0);

    // Extremes
    clear_caps();
    send_frame(fx, 0);
    idle(3);
    check("extreme_count", cap_q.size(), 4);
    check_caps("extreme", ex, 0, 0);

    // Random gaps
    clear_caps();
    send_frame(fa, 5);
    idle(3);
    check("gaps_count", cap_q.size(), 4);
    check_caps("gaps", ea, 0, 0);

    // Back-to-back frames
    clear_caps();
    send_frame(fa, 0);
    send_frame(fb, 0);
    idle(3);
    check("b2b_count", cap_q.size(), 8);
    check_caps("b2b_first", ea, 0, 0);
    check_caps("b2b_second", eb, 4, NB);

    // Reset mid-frame after 6 beats
    clear_caps();
    for (int i = 0; i < 6; i++) beat(fa[i]);
    idle(2);
    check("midrst_pre_count", cap_q.size(), 1);
    if (cap_q.size() > 0) check("midrst_pre_val", cap_q[0], 6);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'sh7FFF;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_data", int'(out_data), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    idle(2);
    clear_caps();
    send_frame(fc, 0);
    idle(3);
    check("fresh_count", cap_q.size(), 4);
    check_caps("fresh", ec, 0, 0);

    // All-zero frame, then quiet period
    clear_caps();
    send_frame(fz, 2);
    idle(3);
    check("zero_count", cap_q.size(), 4);
    check_caps("zero", ez, 0, 0);
    check("zero_state_idle", int'(dut.r_state), int'(IDLE));
    check("zero_col_cnt", int'(dut.r_col_cnt), 0);
    check("zero_row_cnt", int'(dut.r_row_cnt), 0);
    clear_caps();
    idle(20);
    check("quiet_count", cap_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
